// File: rtl/memshare_page_sched_pkg.sv
// Shared definitions for the memShare page-issue scheduler.
// Holds default widths, the FSM state encoding and the page-count clamp.
// No logic of its own; imported by the scheduler top.
package memshare_page_sched_pkg;

  localparam int DEF_MODE_BITWIDTH       = 2;
  localparam int DEF_SHARED_BANK_NUM     = 5;
  localparam int DEF_TYPE0_ADDR_BITWIDTH = DEF_MODE_BITWIDTH + DEF_SHARED_BANK_NUM;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;

  // A page count of zero still issues one page.
  function automatic int unsigned clamp_page_num(input int unsigned page_num);
    return (page_num == 0) ? 1 : page_num;
  endfunction

endpackage

// File: rtl/memshare_page_sched_ctr.sv
// Page index counter: clear, increment, terminal count at page_num-1.
// Latency: index updates on the edge after clr/inc; tc is combinational.
// No backpressure of its own; the caller only asserts inc on a handshake.
module memshare_page_sched_ctr #(
  parameter int WIDTH = 2
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] page_num,
  output logic [WIDTH-1:0] page_idx,
  output logic             tc
);

  // Index register; clear wins over increment.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      page_idx <= '0;
    end else if (clr) begin
      page_idx <= '0;
    end else if (inc) begin
      page_idx <= page_idx + WIDTH'(1);
    end
  end

  // page_num is always >= 1, so page_num-1 never underflows.
  assign tc = (page_idx == page_num - WIDTH'(1));

endmodule

// File: rtl/memshare_page_sched.sv
// Walks L1PA pages of one share request, emitting {page_idx, flags} per handshake.
// Latency: request accepted at edge k -> first address valid in cycle k+1.
// Backpressure: address held while raddr_ready_i low; new request accepted on last-page handshake.
module memshare_page_sched
  import memshare_page_sched_pkg::*;
#(
  parameter int MODE_BITWIDTH       = DEF_MODE_BITWIDTH,
  parameter int SHARED_BANK_NUM     = DEF_SHARED_BANK_NUM,
  parameter int TYPE0_ADDR_BITWIDTH = MODE_BITWIDTH + SHARED_BANK_NUM
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           cen,
  input  logic                           flush_i,
  input  logic                           rqst_valid_i,
  output logic                           rqst_ready_o,
  input  logic [SHARED_BANK_NUM-1:0]     rqst_flag_i,
  input  logic [MODE_BITWIDTH-1:0]       rqst_pageNum_i,
  output logic [TYPE0_ADDR_BITWIDTH-1:0] raddr_o,
  output logic                           raddr_valid_o,
  input  logic                           raddr_ready_i,
  output logic                           raddr_last_o,
  output logic                           busy_o
);

  sched_state_t               state_q, state_d;
  logic [SHARED_BANK_NUM-1:0] flags_q;
  logic [MODE_BITWIDTH-1:0]   page_num_q;
  logic [MODE_BITWIDTH-1:0]   page_idx;
  logic                       ctr_tc;
  logic                       ctr_clr;
  logic                       ctr_inc;
  logic                       load;
  logic                       accept;
  logic                       page_hs;

  assign raddr_valid_o = (state_q == ISSUE) & cen;
  assign raddr_last_o  = (state_q == ISSUE) & ctr_tc;
  assign raddr_o       = {page_idx, flags_q};
  assign busy_o        = raddr_valid_o;
  assign page_hs       = raddr_valid_o & raddr_ready_i;
  assign accept        = rqst_valid_i & rqst_ready_o;

  // Request ready: free in IDLE, or in ISSUE only when the last page is leaving this cycle.
  always_comb begin
    rqst_ready_o = 1'b0;
    if (rstn && cen && !flush_i) begin
      if (state_q == IDLE) begin
        rqst_ready_o = 1'b1;
      end else begin
        rqst_ready_o = raddr_last_o & raddr_ready_i;
      end
    end
  end

  // Next state and counter controls; flush overrides everything, cen low freezes all.
  always_comb begin
    state_d = state_q;
    ctr_clr = 1'b0;
    ctr_inc = 1'b0;
    load    = 1'b0;
    if (cen) begin
      if (flush_i) begin
        state_d = IDLE;
        ctr_clr = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              load    = 1'b1;
              ctr_clr = 1'b1;
              state_d = ISSUE;
            end
          end
          ISSUE: begin
            if (page_hs) begin
              if (ctr_tc) begin
                ctr_clr = 1'b1;
                if (accept) begin
                  load    = 1'b1;
                  state_d = ISSUE;
                end else begin
                  state_d = IDLE;
                end
              end else begin
                ctr_inc = 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture: flags and clamped page count.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      flags_q    <= '0;
      page_num_q <= MODE_BITWIDTH'(1);
    end else if (load) begin
      flags_q    <= rqst_flag_i;
      page_num_q <= MODE_BITWIDTH'(clamp_page_num(32'(rqst_pageNum_i)));
    end
  end

  memshare_page_sched_ctr #(
    .WIDTH (MODE_BITWIDTH)
  ) u_page_ctr (
    .sys_clk  (sys_clk),
    .rstn     (rstn),
    .clr      (ctr_clr),
    .inc      (ctr_inc),
    .page_num (page_num_q),
    .page_idx (page_idx),
    .tc       (ctr_tc)
  );

endmodule

// File: tb/tb_memshare_page_sched.sv
module tb_memshare_page_sched;

  localparam int MW = 2;
  localparam int SB = 5;
  localparam int AW = MW + SB;

  logic          sys_clk        = 1'b0;
  logic          rstn           = 1'b0;
  logic          cen            = 1'b1;
  logic          flush_i        = 1'b0;
  logic          rqst_valid_i   = 1'b0;
  logic [SB-1:0] rqst_flag_i    = '0;
  logic [MW-1:0] rqst_pageNum_i = '0;
  logic          raddr_ready_i  = 1'b1;
  logic          rqst_ready_o;
  logic [AW-1:0] raddr_o;
  logic          raddr_valid_o;
  logic          raddr_last_o;
  logic          busy_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  memshare_page_sched dut (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .cen            (cen),
    .flush_i        (flush_i),
    .rqst_valid_i   (rqst_valid_i),
    .rqst_ready_o   (rqst_ready_o),
    .rqst_flag_i    (rqst_flag_i),
    .rqst_pageNum_i (rqst_pageNum_i),
    .raddr_o        (raddr_o),
    .raddr_valid_o  (raddr_valid_o),
    .raddr_ready_i  (raddr_ready_i),
    .raddr_last_o   (raddr_last_o),
    .busy_o         (busy_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [SB-1:0] flags, input logic [MW-1:0] idx, input logic last);
    exp_t e;
    e.addr = {idx, flags};
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Present a request, expect it to be accepted at the next edge, then drop it.
  task automatic drive_req(input logic [SB-1:0] flags, input logic [MW-1:0] pn);
    rqst_valid_i   = 1'b1;
    rqst_flag_i    = flags;
    rqst_pageNum_i = pn;
    #1;
    check("req_ready", 32'(rqst_ready_o), 1);
    tick();
    rqst_valid_i = 1'b0;
    #1;
  endtask

  // Monitor: every address handshake is compared against the scoreboard.
  always @(negedge sys_clk) begin
    if (rstn && raddr_valid_o && raddr_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: got addr %0h with no expected entry", raddr_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_addr", 32'(raddr_o), 32'(mon_e.addr));
        check("mon_last", 32'(raddr_last_o), 32'(mon_e.last));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_valid", 32'(raddr_valid_o), 0);
    check("rst_ready", 32'(rqst_ready_o), 0);
    check("rst_last", 32'(raddr_last_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_addr", 32'(raddr_o), 0);
    #11;
    rstn = 1'b1;
    #1;
    check("post_rst_ready", 32'(rqst_ready_o), 1);
    tick();

    // Single 2-page request
    push(5'b11001, 2'd0, 1'b0);
    push(5'b11001, 2'd1, 1'b1);
    drive_req(5'b11001, 2'd2);
    check("t1_valid0", 32'(raddr_valid_o), 1);
    check("t1_addr0", 32'(raddr_o), 32'(7'b00_11001));
    check("t1_last0", 32'(raddr_last_o), 0);
    tick();
    check("t1_addr1", 32'(raddr_o), 32'(7'b01_11001));
    check("t1_last1", 32'(raddr_last_o), 1);
    tick();
    check("t1_idle_valid", 32'(raddr_valid_o), 0);
    check("t1_idle_busy", 32'(busy_o), 0);

    // Back-to-back: 3 pages then 1 page, no bubble
    push(5'b11111, 2'd0, 1'b0);
    push(5'b11111, 2'd1, 1'b0);
    push(5'b11111, 2'd2, 1'b1);
    push(5'b10000, 2'd0, 1'b1);
    drive_req(5'b11111, 2'd3);
    check("t2_valid0", 32'(raddr_valid_o), 1);
    tick();
    check("t2_valid1", 32'(raddr_valid_o), 1);
    tick();
    check("t2_valid2", 32'(raddr_valid_o), 1);
    check("t2_last2", 32'(raddr_last_o), 1);
    rqst_valid_i   = 1'b1;
    rqst_flag_i    = 5'b10000;
    rqst_pageNum_i = 2'd1;
    #1;
    check("t2_b2b_ready", 32'(rqst_ready_o), 1);
    tick();
    rqst_valid_i = 1'b0;
    #1;
    check("t2_valid3", 32'(raddr_valid_o), 1);
    check("t2_addr3", 32'(raddr_o), 32'(7'b00_10000));
    check("t2_last3", 32'(raddr_last_o), 1);
    tick();
    check("t2_idle_valid", 32'(raddr_valid_o), 0);

    // Backpressure on page 0 for 3 cycles
    raddr_ready_i = 1'b0;
    push(5'b00110, 2'd0, 1'b0);
    push(5'b00110, 2'd1, 1'b1);
    drive_req(5'b00110, 2'd2);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid", 32'(raddr_valid_o), 1);
      check("t3_hold_addr", 32'(raddr_o), 32'(7'b00_00110));
      check("t3_hold_last", 32'(raddr_last_o), 0);
      tick();
    end
    check("t3_still_page0", 32'(raddr_o), 32'(7'b00_00110));
    raddr_ready_i = 1'b1;
    tick();
    check("t3_addr1", 32'(raddr_o), 32'(7'b01_00110));
    check("t3_last1", 32'(raddr_last_o), 1);
    tick();
    check("t3_idle_valid", 32'(raddr_valid_o), 0);

    // pageNum = 0, flags = 0 -> one page at address 0
    push(5'b00000, 2'd0, 1'b1);
    drive_req(5'b00000, 2'd0);
    check("t4_valid", 32'(raddr_valid_o), 1);
    check("t4_addr", 32'(raddr_o), 0);
    check("t4_last", 32'(raddr_last_o), 1);
    tick();
    check("t4_idle_valid", 32'(raddr_valid_o), 0);

    // cen low for 2 cycles at page 0
    push(5'b11100, 2'd0, 1'b0);
    push(5'b11100, 2'd1, 1'b1);
    drive_req(5'b11100, 2'd2);
    cen = 1'b0;
    #1;
    check("t5_frz_valid", 32'(raddr_valid_o), 0);
    check("t5_frz_ready", 32'(rqst_ready_o), 0);
    check("t5_frz_addr", 32'(raddr_o), 32'(7'b00_11100));
    tick();
    check("t5_frz_valid2", 32'(raddr_valid_o), 0);
    check("t5_frz_addr2", 32'(raddr_o), 32'(7'b00_11100));
    tick();
    cen = 1'b1;
    #1;
    check("t5_resume_valid", 32'(raddr_valid_o), 1);
    check("t5_resume_addr", 32'(raddr_o), 32'(7'b00_11100));
    tick();
    check("t5_addr1", 32'(raddr_o), 32'(7'b01_11100));
    check("t5_last1", 32'(raddr_last_o), 1);
    tick();
    check("t5_idle_valid", 32'(raddr_valid_o), 0);

    // flush at page 1 of a 3-page request
    push(5'b10101, 2'd0, 1'b0);
    push(5'b10101, 2'd1, 1'b0);
    drive_req(5'b10101, 2'd3);
    tick();
    check("t6_addr1", 32'(raddr_o), 32'(7'b01_10101));
    flush_i = 1'b1;
    #1;
    check("t6_flush_ready", 32'(rqst_ready_o), 0);
    tick();
    flush_i = 1'b0;
    #1;
    check("t6_post_valid", 32'(raddr_valid_o), 0);
    check("t6_post_ready", 32'(rqst_ready_o), 1);
    push(5'b01010, 2'd0, 1'b1);
    drive_req(5'b01010, 2'd1);
    check("t6_restart_addr", 32'(raddr_o), 32'(7'b00_01010));
    check("t6_restart_last", 32'(raddr_last_o), 1);
    tick();
    check("t6_idle_valid", 32'(raddr_valid_o), 0);

    // Reset pulse mid-request
    push(5'b00111, 2'd0, 1'b0);
    drive_req(5'b00111, 2'd3);
    tick();
    check("t7_addr1", 32'(raddr_o), 32'(7'b01_00111));
    rstn = 1'b0;
    #1;
    check("t7_rst_valid", 32'(raddr_valid_o), 0);
    check("t7_rst_busy", 32'(busy_o), 0);
    check("t7_rst_addr", 32'(raddr_o), 0);
    @(negedge sys_clk);
    #1;
    rstn = 1'b1;
    tick();
    check("t7_post_valid", 32'(raddr_valid_o), 0);
    check("t7_post_ready", 32'(rqst_ready_o), 1);
    push(5'b11000, 2'd0, 1'b0);
    push(5'b11000, 2'd1, 1'b1);
    drive_req(5'b11000, 2'd2);
    check("t7_restart_addr0", 32'(raddr_o), 32'(7'b00_11000));
    tick();
    check("t7_restart_addr1", 32'(raddr_o), 32'(7'b01_11000));
    tick();
    check("t7_idle_valid", 32'(raddr_valid_o), 0);

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
